// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
//   stage_st_t : occupancy of the stage (no entry, main only, main + skid)
//   NOP_WORD   : encoding of the canonical bubble instruction (sll $0,$0,0)
package pipe_pkg;

    localparam int unsigned NOP_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_st_t;

    localparam logic [NOP_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stall / bubble profiling.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_en    : count this cycle (ignored once the count is all-ones)
//   i_clr   : synchronous clear, wins over i_en
//   o_cnt   : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear first, then increment unless already saturated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// flush-to-bubble and saturating stall/bubble counters.
//   Clock, Reset          : rising-edge clock, async active-low reset
//   In_valid/In_ready     : upstream handshake, In_data is the payload
//   Out_valid/Out_ready   : downstream handshake, Out_data is the head entry
//                           (BUBBLE_VAL whenever Out_valid is low)
//   Flush                 : synchronous kill of held and incoming entries
//   Cnt_clr               : synchronous clear of both counters
//   Stall_cnt/Bubble_cnt  : cycles stalled by downstream / cycles with no entry
// SKID=0 keeps a single entry and a combinational In_ready; SKID=1 adds a
// skid entry so that In_ready comes straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_WORD),
    parameter int unsigned       SKID       = 1,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [DATA_W-1:0] In_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Out_data,
    input  logic              Flush,
    input  logic              Cnt_clr,
    output logic [CNT_W-1:0]  Stall_cnt,
    output logic [CNT_W-1:0]  Bubble_cnt
);

    stage_st_t         r_state;
    stage_st_t         w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic              r_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_pop;

    assign w_accept = In_valid && w_in_ready;
    assign w_pop    = r_valid && Out_ready;

    // State and head-entry registers; Out_valid is a decoded copy of next state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VAL;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_valid <= (w_state_nxt != EMPTY);
        end
    end

    if (SKID != 0) begin : g_skid

        logic [DATA_W-1:0] r_skid;
        logic [DATA_W-1:0] w_skid_nxt;
        logic              r_in_ready;

        // Next-state / datapath for the two-entry skid buffer.
        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = In_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_nxt  = In_data;
                    end else if (w_accept) begin
                        w_state_nxt = TWO;
                        w_skid_nxt  = In_data;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end
            endcase
            // Flush overrides everything; a same-cycle accept is swallowed.
            if (Flush) begin
                w_state_nxt = EMPTY;
                w_main_nxt  = BUBBLE_VAL;
                w_skid_nxt  = BUBBLE_VAL;
            end
        end

        // Skid entry plus the registered ready (full only in TWO).
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_skid     <= BUBBLE_VAL;
                r_in_ready <= 1'b1;
            end else begin
                r_skid     <= w_skid_nxt;
                r_in_ready <= (w_state_nxt != TWO);
            end
        end

        assign w_in_ready = r_in_ready;

    end else begin : g_single

        // Next-state / datapath for the single-entry register.
        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            if (w_accept) begin
                w_state_nxt = ONE;
                w_main_nxt  = In_data;
            end else if (w_pop) begin
                w_state_nxt = EMPTY;
                w_main_nxt  = BUBBLE_VAL;
            end
            if (Flush) begin
                w_state_nxt = EMPTY;
                w_main_nxt  = BUBBLE_VAL;
            end
        end

        // Ready whenever the single entry is free or leaving this cycle.
        assign w_in_ready = Out_ready || !r_valid;

    end

    // Counters look at pre-flush occupancy, so a flush cycle is still counted.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_en    (r_valid && !Out_ready),
        .i_clr   (Cnt_clr),
        .o_cnt   (Stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_en    (!r_valid && Out_ready),
        .i_clr   (Cnt_clr),
        .o_cnt   (Bubble_cnt)
    );

    assign In_ready  = w_in_ready;
    assign Out_valid = r_valid;
    assign Out_data  = r_main;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances driven by the same stimulus
// (SKID=1/CNT_W=16, SKID=0/CNT_W=16, SKID=1/CNT_W=4), each checked every
// cycle against a small FIFO-occupancy model, plus directed spot checks.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 64;
    localparam int unsigned NI = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;
    logic          cnt_clr;

    logic          ov_a, ov_b, ov_c;
    logic          ir_a, ir_b, ir_c;
    logic [DW-1:0] od_a, od_b, od_c;
    logic [15:0]   sc_a, sc_b, bc_a, bc_b;
    logic [3:0]    sc_c, bc_c;

    logic          ov [NI];
    logic          ir [NI];
    logic [DW-1:0] od [NI];
    logic [15:0]   sc [NI];
    logic [15:0]   bc [NI];

    // Reference model: FIFO contents, occupancy, counters per instance.
    logic [DW-1:0] m_buf   [NI][2];
    int            m_n     [NI];
    int            m_stall [NI];
    int            m_bub   [NI];
    bit            m_skid  [NI] = '{1'b1, 1'b0, 1'b1};
    int            m_max   [NI] = '{65535, 65535, 15};

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_skid (
        .Clock(clk), .Reset(rst_n), .In_valid(in_valid), .In_ready(ir_a),
        .In_data(in_data), .Out_valid(ov_a), .Out_ready(out_ready), .Out_data(od_a),
        .Flush(flush), .Cnt_clr(cnt_clr), .Stall_cnt(sc_a), .Bubble_cnt(bc_a)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_single (
        .Clock(clk), .Reset(rst_n), .In_valid(in_valid), .In_ready(ir_b),
        .In_data(in_data), .Out_valid(ov_b), .Out_ready(out_ready), .Out_data(od_b),
        .Flush(flush), .Cnt_clr(cnt_clr), .Stall_cnt(sc_b), .Bubble_cnt(bc_b)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
        .Clock(clk), .Reset(rst_n), .In_valid(in_valid), .In_ready(ir_c),
        .In_data(in_data), .Out_valid(ov_c), .Out_ready(out_ready), .Out_data(od_c),
        .Flush(flush), .Cnt_clr(cnt_clr), .Stall_cnt(sc_c), .Bubble_cnt(bc_c)
    );

    always_comb begin
        ov[0] = ov_a; ov[1] = ov_b; ov[2] = ov_c;
        ir[0] = ir_a; ir[1] = ir_b; ir[2] = ir_c;
        od[0] = od_a; od[1] = od_b; od[2] = od_c;
        sc[0] = sc_a; sc[1] = sc_b; sc[2] = 16'(sc_c);
        bc[0] = bc_a; bc[1] = bc_b; bc[2] = 16'(bc_c);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int i);
        if (m_skid[i]) return (m_n[i] < 2);
        return out_ready || (m_n[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_n[i] = 0; m_stall[i] = 0; m_bub[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit rdy);
        bit pop;
        bit acc;
        pop = (m_n[i] > 0) && out_ready;
        acc = in_valid && rdy;
        if (cnt_clr) begin
            m_stall[i] = 0;
            m_bub[i]   = 0;
        end else begin
            if ((m_n[i] > 0) && !out_ready && (m_stall[i] < m_max[i])) m_stall[i]++;
            if ((m_n[i] == 0) && out_ready && (m_bub[i] < m_max[i])) m_bub[i]++;
        end
        if (flush) begin
            m_n[i] = 0;
        end else begin
            if (pop) begin
                m_buf[i][0] = m_buf[i][1];
                m_n[i]--;
            end
            if (acc) begin
                m_buf[i][m_n[i]] = in_data;
                m_n[i]++;
            end
        end
    endtask

    task automatic check_model(input int i);
        chk($sformatf("u%0d.Out_valid", i), DW'(ov[i]), DW'(m_n[i] > 0));
        chk($sformatf("u%0d.Out_data", i), od[i], (m_n[i] > 0) ? m_buf[i][0] : '0);
        chk($sformatf("u%0d.In_ready", i), DW'(ir[i]), DW'(model_ready(i)));
        chk($sformatf("u%0d.Stall_cnt", i), DW'(sc[i]), DW'(m_stall[i]));
        chk($sformatf("u%0d.Bubble_cnt", i), DW'(bc[i]), DW'(m_bub[i]));
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        bit rdy [NI];
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_model(i);
            rdy[i] = model_ready(i);
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i, rdy[i]);
        #1;
    endtask

    localparam logic [DW-1:0] VA = 64'hAAAA_0000_0000_000A;
    localparam logic [DW-1:0] VB = 64'hBBBB_0000_0000_000B;
    localparam logic [DW-1:0] VC = 64'hCCCC_0000_0000_000C;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset.u%0d.Out_valid", i), DW'(ov[i]), '0);
            chk($sformatf("reset.u%0d.Out_data", i), od[i], '0);
            chk($sformatf("reset.u%0d.In_ready", i), DW'(ir[i]), DW'(1));
            chk($sformatf("reset.u%0d.Stall_cnt", i), DW'(sc[i]), '0);
            chk($sformatf("reset.u%0d.Bubble_cnt", i), DW'(bc[i]), '0);
        end
        rst_n = 1'b1;

        // Streaming 1..8 with one cycle of latency.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, DW'(k + 1), 1'b1, 1'b0, 1'b0);
            chk("stream.skid.data", od[0], DW'(k + 1));
            chk("stream.single.data", od[1], DW'(k + 1));
        end
        chk("stream.skid.bubble", DW'(bc[0]), DW'(1));
        chk("stream.single.bubble", DW'(bc[1]), DW'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall with A, B held for three Out_ready=0 cycles.
        cycle(1'b1, VA, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, VB, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall.in_ready", DW'(ir[0]), '0);
        chk("stall.data_hold", od[0], VA);
        chk("stall.stall_cnt", DW'(sc[0]), DW'(3));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall.release_b", od[0], VB);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall.drained", DW'(ov[0]), '0);

        // Flush in TWO with C offered; then flush swallowing an accept in ONE.
        cycle(1'b1, 64'hD, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hE, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, VC, 1'b0, 1'b1, 1'b0);
        chk("flush.valid", DW'(ov[0]), '0);
        chk("flush.data", od[0], '0);
        chk("flush.in_ready", DW'(ir[0]), DW'(1));
        cycle(1'b1, 64'hF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h6, 1'b0, 1'b1, 1'b0);
        chk("flush.accept_dropped", DW'(ov[0]), '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle while in TWO.
        cycle(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        chk("areset.pre_full", DW'(ir[0]), '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.valid", DW'(ov[0]), '0);
        chk("areset.data", od[0], '0);
        chk("areset.stall", DW'(sc[0]), '0);
        chk("areset.bubble", DW'(bc[0]), '0);
        chk("areset.in_ready", DW'(ir[0]), DW'(1));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter saturation on the 4-bit instance, then clear during a stall.
        cycle(1'b1, 64'h77, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat.stall_cnt4", DW'(sc[2]), DW'(15));
        chk("sat.stall_cnt16", DW'(sc[0]), DW'(20));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat.clr_wins", DW'(sc[2]), '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with unique tagged payloads.
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  {32'($urandom), 32'(n)},
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 255) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
